// File: rtl/jtkiwi_tilemap_gen_if.sv
// Drawer-side link of the column-scroll tilemap engine: tile draw requests
// towards the external drawer and the drawer's line-buffer write port.
interface jtkiwi_tilemap_gen_if #(
    parameter int HW   = 9,
    parameter int PXLW = 9
);
    logic            dr_draw;
    logic            dr_busy;
    logic [15:0]     dr_code;
    logic [15:0]     dr_attr;
    logic [HW-1:0]   dr_xpos;
    logic [3:0]      dr_ysub;
    logic [HW-1:0]   buf_addr;
    logic            buf_we;
    logic [PXLW-1:0] buf_din;

    modport master (
        output dr_draw, dr_code, dr_attr, dr_xpos, dr_ysub,
        input  dr_busy, buf_addr, buf_we, buf_din
    );

    modport slave (
        input  dr_draw, dr_code, dr_attr, dr_xpos, dr_ysub,
        output dr_busy, buf_addr, buf_we, buf_din
    );
endinterface

// File: rtl/jtkiwi_tilemap_gen.sv
// Column-scroll tilemap engine: walks one line of tiles, fetches scroll and
// LUT words, issues draw requests and owns the drawer's double line buffer.
module jtkiwi_tilemap_gen #(
    parameter int CNTW = 5,
    parameter int PXLW = 9,
    parameter int VMAX = 223,
    parameter int HW   = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lut_cen,
    input  logic            hs,
    input  logic            flip,
    input  logic            page,
    input  logic            col_mode,
    input  logic [3:0]      col_cfg,
    input  logic [7:0]      gscr_x,
    input  logic [7:0]      gscr_y,
    output logic [11:0]     lut_addr,
    input  logic [15:0]     lut_data,
    output logic [7:0]      col_addr,
    input  logic [7:0]      col_data,
    jtkiwi_tilemap_gen_if.master drw,
    input  logic [HW-1:0]   vrender,
    input  logic [HW-1:0]   hdump,
    output logic [PXLW-1:0] pxl
);

    typedef enum logic [1:0] {ST_YSCR, ST_XSCR, ST_CODE, ST_ATTR} st_t;

    st_t             st, st_nx;
    logic [CNTW-1:0] col_cnt, cnt_init, eff_h_col;
    logic [CNTW-2:0] cnt_neg;
    logic            done, line, hsl;
    logic            setup, step, issue, st_lsb;
    logic [7:0]      xscr, yscr, vy;
    logic [3:0]      eff_v_hi;
    logic [15:0]     code;
    logic [HW-1:0]   tile_x;

    logic [PXLW-1:0] mem [0:2**(HW+1)-1];
    logic [HW:0]     wr_addr, rd_addr;
    logic [PXLW-1:0] wr_data;
    logic            wr_en;

    always_comb begin
        setup    = hs || (vrender > HW'(VMAX)) || (col_cfg == '0);
        step     = !setup && !done && lut_cen;
        cnt_neg  = (CNTW-1)'(~col_cfg) + (CNTW-1)'(1);
        cnt_init = (col_cfg == 4'd1) ? '0 : {cnt_neg, 1'b0};
        vy       = flip ? ~vrender[7:0] : vrender[7:0];
        tile_x   = HW'({col_cnt, 4'd0});
        // Only the upper nibbles of eff_v/eff_h feed the address: the tile
        // column has a zero low nibble, so eff_h needs no carry-in, while
        // eff_v takes the carry out of the low-nibble sum.
        eff_v_hi  = vy[7:4] + yscr[7:4] + {3'd0, vy[3:0] > ~yscr[3:0]};
        eff_h_col = col_cnt + CNTW'(xscr[7:4]);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst || setup) st <= ST_YSCR;
        else              st <= st_nx;
    end

    // Next-state logic
    always_comb begin
        st_nx = st;
        if (step) begin
            case (st)
                ST_YSCR: st_nx = ST_XSCR;
                ST_XSCR: st_nx = ST_CODE;
                ST_CODE: st_nx = ST_ATTR;
                ST_ATTR: if (!drw.dr_busy) st_nx = ST_YSCR;
                default: st_nx = ST_YSCR;
            endcase
        end
    end

    // Output logic
    always_comb begin
        st_lsb   = (st == ST_XSCR) || (st == ST_ATTR);
        issue    = step && (st == ST_ATTR) && !drw.dr_busy;
        col_addr = 8'({col_cnt[CNTW-1:1], st_lsb, 3'd0});
        lut_addr = {page, 1'b1, st_lsb, eff_v_hi, eff_h_col};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt      <= '0;
            done         <= 1'b0;
            xscr         <= '0;
            yscr         <= '0;
            code         <= '0;
            drw.dr_draw  <= 1'b0;
            drw.dr_code  <= '0;
            drw.dr_attr  <= '0;
            drw.dr_xpos  <= '0;
            drw.dr_ysub  <= '0;
        end else if (setup) begin
            col_cnt      <= cnt_init;
            done         <= 1'b0;
            drw.dr_draw  <= 1'b0;
            drw.dr_code  <= '0;
            drw.dr_attr  <= '0;
            drw.dr_xpos  <= '0;
            drw.dr_ysub  <= '0;
        end else begin
            drw.dr_draw <= 1'b0;
            if (step) begin
                case (st)
                    ST_YSCR: yscr <= col_mode ? col_data : gscr_y;
                    ST_XSCR: xscr <= col_mode ? col_data : gscr_x;
                    ST_CODE: code <= lut_data;
                    default: ;
                endcase
            end
            if (issue) begin
                drw.dr_draw <= 1'b1;
                drw.dr_code <= code;
                drw.dr_attr <= lut_data;
                drw.dr_xpos <= tile_x - HW'(xscr[3:0]);
                drw.dr_ysub <= vy[3:0] - yscr[3:0];
                col_cnt     <= col_cnt + CNTW'(1);
                done        <= &col_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsl  <= 1'b0;
            line <= 1'b0;
        end else begin
            hsl <= hs;
            if (hs && !hsl) line <= ~line;
        end
    end

    // Write half is cleared pixel by pixel during hs; drawer writes otherwise
    always_comb begin
        wr_addr = {line, hs ? hdump : drw.buf_addr};
        wr_data = hs ? '0 : drw.buf_din;
        wr_en   = hs || drw.buf_we;
        rd_addr = {~line, flip ? ~hdump : hdump};
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        pxl <= mem[rd_addr];
    end

endmodule

// File: tb/tb_jtkiwi_tilemap_gen.sv
// Directed bench for jtkiwi_tilemap_gen with a LUT model returning {4'hA, addr}.
module tb_jtkiwi_tilemap_gen;
    localparam int HW   = 9;
    localparam int PXLW = 9;

    logic            clk = 1'b0;
    logic            rst, lut_cen, hs, flip, page, col_mode;
    logic [3:0]      col_cfg;
    logic [7:0]      gscr_x, gscr_y, col_data, col_addr;
    logic [11:0]     lut_addr;
    logic [15:0]     lut_data;
    logic [HW-1:0]   vrender, hdump;
    logic [PXLW-1:0] pxl;

    int total = 0;
    int bad   = 0;

    logic [HW-1:0] xq[$];
    int            cq[$];
    int            npulse;

    always #5 clk = ~clk;

    jtkiwi_tilemap_gen_if #(.HW(HW), .PXLW(PXLW)) drw();

    assign lut_data = {4'hA, lut_addr};

    jtkiwi_tilemap_gen #(.CNTW(5), .PXLW(PXLW), .VMAX(223), .HW(HW)) dut (
        .clk(clk), .rst(rst), .lut_cen(lut_cen), .hs(hs), .flip(flip),
        .page(page), .col_mode(col_mode), .col_cfg(col_cfg),
        .gscr_x(gscr_x), .gscr_y(gscr_y), .lut_addr(lut_addr),
        .lut_data(lut_data), .col_addr(col_addr), .col_data(col_data),
        .drw(drw), .vrender(vrender), .hdump(hdump), .pxl(pxl)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_line();
        hs = 1'b1;
        tick();
        tick();
        hs = 1'b0;
    endtask

    task automatic collect(input int n);
        xq.delete();
        cq.delete();
        for (int i = 1; i <= n; i++) begin
            tick();
            if (drw.dr_draw === 1'b1) begin
                xq.push_back(drw.dr_xpos);
                cq.push_back(i);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (drw.dr_draw !== 1'b0) begin bad++; $display("FAIL reset_draw got=%0h want=0", drw.dr_draw); end
        total++; if (drw.dr_code !== 16'h0) begin bad++; $display("FAIL reset_code got=%0h want=0", drw.dr_code); end
        total++; if (drw.dr_attr !== 16'h0) begin bad++; $display("FAIL reset_attr got=%0h want=0", drw.dr_attr); end
        total++; if (drw.dr_xpos !== 9'h0) begin bad++; $display("FAIL reset_xpos got=%0h want=0", drw.dr_xpos); end
        total++; if (drw.dr_ysub !== 4'h0) begin bad++; $display("FAIL reset_ysub got=%0h want=0", drw.dr_ysub); end
    endtask

    task automatic test_full_line();
        col_cfg = 4'd1; col_mode = 1'b1; col_data = 8'h00; vrender = 9'h020;
        start_line();
        tick();
        total++; if (col_addr !== 8'h08) begin bad++; $display("FAIL col_addr_st1 got=%0h want=08", col_addr); end
        collect(160);
        total++; if (xq.size() != 32) begin bad++; $display("FAIL full_count got=%0d want=32", xq.size()); end
        if (xq.size() == 32) begin
            total++; if (cq[0] != 3) begin bad++; $display("FAIL full_first_cycle got=%0d want=3", cq[0]); end
            for (int i = 0; i < 32; i++) begin
                total++;
                if (xq[i] !== 9'(16 * i)) begin bad++; $display("FAIL full_xpos[%0d] got=%0h want=%0h", i, xq[i], 16 * i); end
                if (i > 0) begin
                    total++;
                    if (cq[i] - cq[i-1] != 4) begin bad++; $display("FAIL full_spacing[%0d] got=%0d want=4", i, cq[i] - cq[i-1]); end
                end
            end
        end
    endtask

    task automatic test_col_cfg4();
        col_cfg = 4'd4;
        start_line();
        collect(100);
        total++; if (xq.size() != 8) begin bad++; $display("FAIL cfg4_count got=%0d want=8", xq.size()); end
        if (xq.size() == 8) begin
            total++; if (xq[0] !== 9'd384) begin bad++; $display("FAIL cfg4_first_xpos got=%0d want=384", xq[0]); end
            total++; if (xq[7] !== 9'd496) begin bad++; $display("FAIL cfg4_last_xpos got=%0d want=496", xq[7]); end
        end
    endtask

    task automatic test_global_scroll();
        col_cfg = 4'd1; col_mode = 1'b0; gscr_x = 8'h25; gscr_y = 8'h13;
        vrender = 9'h020; flip = 1'b0;
        start_line();
        tick();
        tick();
        total++; if (lut_addr !== 12'h462) begin bad++; $display("FAIL gs_lut_addr got=%0h want=462", lut_addr); end
        tick();
        tick();
        total++; if (drw.dr_draw !== 1'b1) begin bad++; $display("FAIL gs_draw got=%0h want=1", drw.dr_draw); end
        total++; if (drw.dr_xpos !== 9'h1FB) begin bad++; $display("FAIL gs_xpos got=%0h want=1fb", drw.dr_xpos); end
        total++; if (drw.dr_ysub !== 4'hD) begin bad++; $display("FAIL gs_ysub got=%0h want=d", drw.dr_ysub); end
        total++; if (drw.dr_code !== 16'hA462) begin bad++; $display("FAIL gs_code got=%0h want=a462", drw.dr_code); end
        total++; if (drw.dr_attr !== 16'hA662) begin bad++; $display("FAIL gs_attr got=%0h want=a662", drw.dr_attr); end
    endtask

    task automatic test_busy();
        drw.dr_busy = 1'b1;
        start_line();
        tick(); tick(); tick();
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (drw.dr_draw === 1'b1) npulse++;
        end
        total++; if (npulse != 0) begin bad++; $display("FAIL busy_hold_pulses got=%0d want=0", npulse); end
        total++; if (lut_addr !== 12'h662) begin bad++; $display("FAIL busy_lut_addr got=%0h want=662", lut_addr); end
        drw.dr_busy = 1'b0;
        tick();
        drw.dr_busy = 1'b1;
        total++; if (drw.dr_draw !== 1'b1) begin bad++; $display("FAIL busy_release_draw got=%0h want=1", drw.dr_draw); end
        total++; if (drw.dr_code !== 16'hA462) begin bad++; $display("FAIL busy_code got=%0h want=a462", drw.dr_code); end
        total++; if (drw.dr_attr !== 16'hA662) begin bad++; $display("FAIL busy_attr got=%0h want=a662", drw.dr_attr); end
        total++; if (drw.dr_xpos !== 9'h1FB) begin bad++; $display("FAIL busy_xpos got=%0h want=1fb", drw.dr_xpos); end
        npulse = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (drw.dr_draw === 1'b1) npulse++;
        end
        total++; if (npulse != 0) begin bad++; $display("FAIL busy_single_pulse extra=%0d want=0", npulse); end
        drw.dr_busy = 1'b0;
    endtask

    task automatic test_line_buffer();
        col_cfg = 4'd0; flip = 1'b0; hdump = 9'd100;
        do_reset();
        drw.buf_addr = 9'd5; drw.buf_din = 9'h155; drw.buf_we = 1'b1;
        tick();
        drw.buf_we = 1'b0;
        start_line();
        hdump = 9'd5;
        tick();
        total++; if (pxl !== 9'h155) begin bad++; $display("FAIL buf_read got=%0h want=155", pxl); end
        flip = 1'b1; hdump = 9'd506;
        tick();
        total++; if (pxl !== 9'h155) begin bad++; $display("FAIL buf_read_flip got=%0h want=155", pxl); end
        flip = 1'b0; hdump = 9'd5;
        hs = 1'b1;
        tick(); tick(); tick();
        hs = 1'b0;
        hdump = 9'd100;
        start_line();
        hdump = 9'd5;
        tick();
        total++; if (pxl !== 9'h000) begin bad++; $display("FAIL buf_cleared got=%0h want=0", pxl); end
    endtask

    task automatic test_reset_midline();
        do_reset();
        col_cfg = 4'd1; col_mode = 1'b1; col_data = 8'h00; vrender = 9'h020;
        flip = 1'b0; drw.dr_busy = 1'b0;
        start_line();
        for (int i = 0; i < 10; i++) tick();
        total++; if (drw.dr_xpos !== 9'd16) begin bad++; $display("FAIL mid_xpos_pre got=%0d want=16", drw.dr_xpos); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (drw.dr_draw !== 1'b0) begin bad++; $display("FAIL mid_rst_draw got=%0h want=0", drw.dr_draw); end
        total++; if (drw.dr_xpos !== 9'h0) begin bad++; $display("FAIL mid_rst_xpos got=%0h want=0", drw.dr_xpos); end
        total++; if (drw.dr_code !== 16'h0) begin bad++; $display("FAIL mid_rst_code got=%0h want=0", drw.dr_code); end
        total++; if (drw.dr_attr !== 16'h0) begin bad++; $display("FAIL mid_rst_attr got=%0h want=0", drw.dr_attr); end
        vrender = 9'd224;
        start_line();
        collect(150);
        total++; if (xq.size() != 0) begin bad++; $display("FAIL idle_line_draws got=%0d want=0", xq.size()); end
    endtask

    initial begin
        rst = 1'b1; lut_cen = 1'b1; hs = 1'b0; flip = 1'b0; page = 1'b0;
        col_mode = 1'b1; col_cfg = 4'd0; gscr_x = '0; gscr_y = '0;
        col_data = '0; vrender = '0; hdump = '0;
        drw.dr_busy = 1'b0; drw.buf_addr = '0; drw.buf_we = 1'b0; drw.buf_din = '0;
        test_reset();
        test_full_line();
        test_col_cfg4();
        test_global_scroll();
        test_busy();
        test_line_buffer();
        test_reset_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtkiwi_tilemap_gen.md
Name: jtkiwi_tilemap_gen

Overview:
- Parametrised column-scroll tilemap engine for the SETA-style video chip.
- Walks one scanline's worth of tiles during active line time and reads per-column or global scroll values plus two tile-LUT words per tile.
- Issues draw requests to an external tile drawer, which writes a private double line buffer; the buffer is read out on the following line.
- Adds global-scroll mode, screen flip and a configurable line count.

Parameters:
CNTW, 5, tile counter width; 2^CNTW 16-pixel tiles processed per line
PXLW, 9, line-buffer pixel width (palette+colour)
VMAX, 223, last active vrender line; lines above are idle
HW, 9, width of hdump/vrender/xpos

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
lut_cen  in  1  LUT/scroll access enable; state advances only when high
hs  in  1  horizontal sync; high = line setup and buffer clear
flip  in  1  screen flip
page  in  1  LUT page select
col_mode  in  1  1 = per-column scroll from col_data, 0 = global scroll from gscr_x/gscr_y
col_cfg  in  4  column count config; 0 = layer disabled
gscr_x  in  8  global X scroll
gscr_y  in  8  global Y scroll
lut_addr  out  12  tile LUT address
lut_data  in  16  tile LUT data; read latency is met by lut_cen pacing
col_addr  out  8  column scroll RAM address
col_data  in  8  column scroll data
dr_draw  out  1  one-cycle draw request
dr_busy  in  1  drawer busy
dr_code  out  16  tile code
dr_attr  out  16  tile attribute
dr_xpos  out  HW  tile X on line buffer
dr_ysub  out  4  row inside tile
buf_addr  in  HW  drawer write address
buf_we  in  1  drawer write enable
buf_din  in  PXLW  drawer write data
vrender  in  HW  line being rendered
hdump  in  HW  pixel being displayed
pxl  out  PXLW  line-buffer pixel, one cycle after hdump

Behaviour:
Clock and reset:
- Single clock clk; rst is synchronous, active-high.
- On reset: col_cnt=0, st=0, done=0, line=0, dr_draw=0, dr_code/dr_attr/dr_xpos/dr_ysub=0; pxl = RAM output.

Line select:
- line toggles on each rising edge of hs (hs registered as hsl).
- Write half = line; read half = ~line.

Setup (hs=1, vrender>VMAX, or col_cfg=0):
- col_cnt <= (col_cfg==1) ? 0 : {(-col_cfg)[CNTW-2:0],1'b0}.
- st <= 0, done <= 0, dr_draw <= 0, dr_* registers <= 0.
- Setup has priority over any in-flight step.

Sequencer (setup inactive, !done, lut_cen=1), st 0→1→2→3→0:
- st0: yscr <= col_mode ? col_data : gscr_y.
- st1: xscr <= col_mode ? col_data : gscr_x.
- st2: code <= lut_data.
- st3, dr_busy=0: pulse dr_draw for one cycle and issue the tile:
  - dr_code <= code, dr_attr <= lut_data.
  - dr_xpos <= {col_cnt,4'd0} − xscr[3:0], modulo 2^HW.
  - dr_ysub <= vy[3:0] − yscr[3:0].
  - col_cnt++ (wraps); done <= &col_cnt.
- st3, dr_busy=1: st holds; no request is issued.

Arithmetic:
- vy = flip ? ~vrender : vrender.
- eff_v = vy + {0,yscr}.
- eff_h = {col_cnt,4'd0} + {0,xscr}; both modulo 2^HW.

Addresses:
- col_addr = {col_cnt[4:1], st[0], 3'd0}.
- lut_addr = {page, 1'b1, st[0], eff_v[7:4], eff_h[8:4]}.

Line buffer: dual-port, 2^(HW+1) × PXLW.
- Write port, hs=1: address {line,hdump}, data 0, we=1 (clear).
- Write port, hs=0: address {line,buf_addr}, data buf_din, we=buf_we.
- Read port: address {~line, flip ? ~hdump : hdump}; pxl is registered, latency 1.

Edge cases:
- hs rising mid-tile aborts the line; a dr_draw already issued is not retracted.
- col_cfg changes take effect at the next setup.

Test Plan:
1. Reset, then col_cfg=1, col_mode=1, lut_cen=1, dr_busy=0, col_data=0 → 32 dr_draw pulses, 4 cycles apart; dr_xpos = 0, 16, …, 496; done set after col_cnt=31.
2. col_cfg=4 → first col_cnt=24 (−4=12, shifted left = 24); 8 draws; first dr_xpos=384.
3. col_mode=0, gscr_x=0x25, gscr_y=0x13, vrender=0x20, flip=0 → first dr_xpos=0x1FB, dr_ysub=0xD, lut_addr in st2 = {0,1,0,eff_v[7:4]=3,eff_h[8:4]=2}.
4. Hold dr_busy=1 for 10 cycles in st3 → st stays 3, no dr_draw; release → exactly one pulse with correct code/attr.
5. Write 0x155 at buf_addr 5 on line 0, toggle hs → pxl=0x155 one cycle after hdump=5; with flip=1, it appears at hdump=506; after the next hs clear, address 5 reads 0.
6. Assert rst mid-line at st=2 → all dr_* outputs 0 next cycle; vrender=224 → no dr_draw for that line.
